imem_responder: RTL

- Responder end of the instruction memory valid/ready interface driven by the fetch stage.
- Contains a word-organised, byte-writable synchronous RAM and a small FSM that accepts one request at a time.
- Inserts a programmable number of wait states, then answers with a one-cycle ready pulse and read data.
- Used as on-chip instruction memory in the core testbench and FPGA top level.

---
 rtl/riscv_defines.sv | 13 +
 rtl/imem_ram.sv | 39 +++
 rtl/imem_responder.sv | 114 +++++++++++
 3 files changed

// File: rtl/riscv_defines.sv
// Shared core definitions: bus widths and the instruction memory FSM state.
// Imported by the imem responder and its RAM.
package riscv_defines;

    localparam int unsigned RISCV_ADDR_WIDTH = 32;
    localparam int unsigned RISCV_WORD_WIDTH = 32;

    typedef enum logic {
        IMEM_IDLE,
        IMEM_BUSY
    } imem_state_t;

endpackage

// File: rtl/imem_ram.sv
// Word RAM: sync read port, byte-masked
// write port, same clock.
module imem_ram
  import riscv_defines::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter              INIT_FILE   = ""
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           rd_en_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] rd_idx_i,
  output logic [RISCV_WORD_WIDTH-1:0]    rd_data_o,
  input  logic                           wr_en_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] wr_idx_i,
  input  logic [3:0]                     wr_be_i,
  input  logic [RISCV_WORD_WIDTH-1:0]    wr_data_i
);

  logic [RISCV_WORD_WIDTH-1:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be_i[b])
          mem_q[wr_idx_i][8*b +: 8] <= wr_data_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_o <= '0;
    end else if (rd_en_i) begin
      rd_data_o <= mem_q[rd_idx_i];
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction memory responder: IDLE/BUSY handshake FSM, wait-state counter.
// Optional address bounds checking under IMEM_BOUNDS_CHECK_EN.
module imem_responder
    import riscv_defines::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 0,
    parameter              INIT_FILE   = ""
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        imem_valid_i,
    output logic                        imem_ready_o,
    input  logic [RISCV_ADDR_WIDTH-1:0] imem_addr_i,
    input  logic [RISCV_WORD_WIDTH-1:0] imem_wdata_i,
    input  logic [3:0]                  imem_we_i,
`ifdef IMEM_BOUNDS_CHECK_EN
    output logic                        imem_err_o,
`endif
    output logic [RISCV_WORD_WIDTH-1:0] imem_rdata_o
);

    localparam int unsigned IW = $clog2(DEPTH_WORDS);

    imem_state_t                 state_q, state_d;
    logic [3:0]                  cnt_q, cnt_d;
    logic [IW-1:0]               idx_q;
    logic [3:0]                  we_q;
    logic [RISCV_WORD_WIDTH-1:0] wdata_q;
    logic                        oob_q, oob_d;
    logic                        accept;
    logic                        ready;
    logic                        wr_en;
    logic [RISCV_WORD_WIDTH-1:0] ram_rdata;
    logic                        unused_addr;

    assign unused_addr = ^imem_addr_i;
    assign accept      = rst_n && (state_q == IMEM_IDLE) && imem_valid_i;

`ifdef IMEM_BOUNDS_CHECK_EN
    assign oob_d        = (imem_addr_i >> (IW + 2)) != '0;
    assign imem_err_o   = ready && oob_q;
`else
    assign oob_d        = 1'b0;
`endif

    // Out-of-range responses return zero and never touch the array.
    assign wr_en        = ready && !oob_q;
    assign imem_ready_o = ready;
    assign imem_rdata_o = (ready && oob_q) ? '0 : ram_rdata;

    // Next state, wait countdown and the combinational ready strobe.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready   = 1'b0;
        unique case (state_q)
            IMEM_IDLE: begin
                if (imem_valid_i) begin
                    state_d = IMEM_BUSY;
                    cnt_d   = 4'(WAIT_STATES);
                end
            end
            IMEM_BUSY: begin
                if (!imem_valid_i) begin
                    state_d = IMEM_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    ready   = rst_n;
                    state_d = IMEM_IDLE;
                end
            end
            default: state_d = IMEM_IDLE;
        endcase
    end

    // State, counter and request latch captured on acceptance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IMEM_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            we_q    <= '0;
            wdata_q <= '0;
            oob_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                idx_q   <= imem_addr_i[IW+1:2];
                we_q    <= imem_we_i;
                wdata_q <= imem_wdata_i;
                oob_q   <= oob_d;
            end
        end
    end

    imem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .INIT_FILE   (INIT_FILE)
    ) u_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_en_i   (accept),
        .rd_idx_i  (imem_addr_i[IW+1:2]),
        .rd_data_o (ram_rdata),
        .wr_en_i   (wr_en),
        .wr_idx_i  (idx_q),
        .wr_be_i   (we_q),
        .wr_data_i (wdata_q)
    );

endmodule
